// File: rtl/relu_argmax_stage.sv
// relu_argmax_stage
// Captures one N-element signed vector, then walks it one element per cycle
// applying ReLU while tracking the largest activation, its index and the
// number of strictly positive inputs. The result is held until consumed.
//
// Ports:
//   clk        - clock, all state updates on the rising edge
//   rst_n      - asynchronous active-low reset
//   in_valid   - upstream offers a vector on `in`
//   in_ready   - high only while idle; an accept happens on in_valid && in_ready
//   in         - pre-activation vector, N signed WIDTH-bit elements
//   out_valid  - high only while a finished result is presented
//   out_ready  - downstream consumes the result on out_valid && out_ready
//   act_out    - ReLU of the captured vector
//   max_idx    - index of the largest activation (lowest index on ties)
//   max_val    - largest activation (0 if no element is positive)
//   num_active - count of strictly positive elements
module relu_argmax_stage #(
    parameter int WIDTH = 16,
    parameter int N     = 4,
    localparam int IW   = (N <= 2) ? 1 : $clog2(N),
    localparam int CW   = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] in [0:N-1],
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] act_out [0:N-1],
    output logic [IW-1:0]           max_idx,
    output logic signed [WIDTH-1:0] max_val,
    output logic [CW-1:0]           num_active
);

    localparam logic [IW-1:0] LAST = IW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic signed [WIDTH-1:0] vec [0:N-1];
    logic [IW-1:0]           k;
    logic signed [WIDTH-1:0] elem;
    logic signed [WIDTH-1:0] act;

    // ReLU by sign bit: negative values clamp to zero; the result can never
    // exceed the input range, so no saturation is needed.
    function automatic logic signed [WIDTH-1:0] relu(input logic signed [WIDTH-1:0] x);
        return x[WIDTH-1] ? '0 : x;
    endfunction

    assign elem = vec[k];
    assign act  = relu(elem);

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (in_valid)   next_state = SCAN;
            SCAN:    if (k == LAST)  next_state = DONE;
            DONE:    if (out_ready)  next_state = IDLE;
            default:                 next_state = IDLE;
        endcase
    end

    // Capture stage (IDLE) feeds the sequential scan (SCAN); DONE only holds.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec        <= '{default: '0};
            act_out    <= '{default: '0};
            max_idx    <= '0;
            max_val    <= '0;
            num_active <= '0;
            k          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        vec        <= in;
                        max_idx    <= '0;
                        max_val    <= '0;
                        num_active <= '0;
                        k          <= '0;
                    end
                end
                SCAN: begin
                    act_out[k] <= act;
                    // Strict compare keeps the earliest index on ties; the
                    // running max starts at 0 so all-nonpositive gives idx 0.
                    if (act > max_val) begin
                        max_val <= act;
                        max_idx <= k;
                    end
                    // A nonzero activation means the element was strictly positive.
                    if (act != '0) begin
                        num_active <= num_active + CW'(1);
                    end
                    // Index parks on the last element rather than wrapping.
                    if (k != LAST) begin
                        k <= k + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_relu_argmax_stage.sv
module tb_relu_argmax_stage;

    localparam int W = 16;
    localparam int N = 4;

    typedef logic signed [W-1:0] vec_t [0:N-1];

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    vec_t        din;
    logic        out_valid;
    logic        out_ready = 1'b0;
    vec_t        act_out;
    logic [1:0]  max_idx;
    logic signed [W-1:0] max_val;
    logic [2:0]  num_active;

    int tests = 0;
    int fails = 0;

    vec_t exp_act;
    int   exp_idx, exp_val, exp_cnt;

    always #5 clk = ~clk;

    relu_argmax_stage #(.WIDTH(W), .N(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in         (din),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .act_out    (act_out),
        .max_idx    (max_idx),
        .max_val    (max_val),
        .num_active (num_active)
    );

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Reference: activations, then the maximum of them, then the first
    // position holding that maximum, and a count of positives.
    task automatic model(input vec_t v);
        int mx;
        mx = 0;
        exp_cnt = 0;
        for (int i = 0; i < N; i++) begin
            exp_act[i] = (int'(v[i]) < 0) ? W'(0) : v[i];
            if (int'(v[i]) > 0) exp_cnt++;
            if (int'(exp_act[i]) > mx) mx = int'(exp_act[i]);
        end
        exp_val = mx;
        exp_idx = 0;
        for (int i = N - 1; i >= 0; i--)
            if (int'(exp_act[i]) == mx) exp_idx = i;
    endtask

    task automatic check_out(input string tag);
        for (int i = 0; i < N; i++)
            check($sformatf("%s_act%0d", tag, i), act_out[i], exp_act[i]);
        check({tag, "_idx"}, max_idx, exp_idx);
        check({tag, "_val"}, max_val, exp_val);
        check({tag, "_cnt"}, num_active, exp_cnt);
    endtask

    task automatic scramble_in();
        for (int i = 0; i < N; i++) din[i] = W'($urandom);
    endtask

    task automatic accept_and_wait(input vec_t v, input string tag);
        int lat;
        model(v);
        din = v;
        in_valid = 1'b1;
        check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        scramble_in();
        lat = 0;
        while (!out_valid && lat < N + 4) begin
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, lat, N);
        check_out(tag);
        check({tag, "_busy"}, in_ready, 0);
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_ov_drop"}, out_valid, 0);
        check({tag, "_idle"}, in_ready, 1);
    endtask

    task automatic run_vector(input vec_t v, input string tag);
        accept_and_wait(v, tag);
        consume(tag);
    endtask

    function automatic vec_t rand_vec();
        vec_t v;
        int   t;
        for (int i = 0; i < N; i++) begin
            if ($urandom_range(0, 1) == 0) begin
                v[i] = W'($urandom);
            end else begin
                t = int'($urandom_range(0, 6)) - 3;
                v[i] = W'(t);
            end
        end
        return v;
    endfunction

    vec_t v;
    vec_t bvec [0:2];

    initial begin
        int cyc, acc_n, res_n, last_acc;
        bit seen, accepting;

        scramble_in();
        // Reset state
        #2 rst_n = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_idx", max_idx, 0);
        check("rst_val", max_val, 0);
        check("rst_cnt", num_active, 0);
        for (int i = 0; i < N; i++) check($sformatf("rst_act%0d", i), act_out[i], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed vectors; the first accept lands on the first edge after release.
        v = '{16'sd3, -16'sd2, 16'sd7, 16'sd1};
        run_vector(v, "basic");
        v = '{16'sd5, 16'sd5, -16'sd1, 16'sd5};
        run_vector(v, "tie");
        v = '{-16'sd1, -16'sd32768, 16'sd0, -16'sd5};
        run_vector(v, "nonpos");

        // Hold in DONE while the input side wiggles.
        v = '{16'sd100, -16'sd7, 16'sd250, 16'sd250};
        accept_and_wait(v, "hold");
        for (int c = 0; c < 10; c++) begin
            scramble_in();
            in_valid = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            check($sformatf("hold%0d_ov", c), out_valid, 1);
            check($sformatf("hold%0d_ir", c), in_ready, 0);
            check_out($sformatf("hold%0d", c));
        end
        in_valid = 1'b0;
        consume("hold");

        // Reset during the scan discards the vector.
        v = '{16'sd9, 16'sd8, 16'sd7, 16'sd6};
        din = v;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mrst_ir", in_ready, 1);
        check("mrst_ov", out_valid, 0);
        check("mrst_idx", max_idx, 0);
        check("mrst_val", max_val, 0);
        check("mrst_cnt", num_active, 0);
        for (int i = 0; i < N; i++) check($sformatf("mrst_act%0d", i), act_out[i], 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < N + 3; c++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        check("mrst_no_ov", seen, 0);
        v = '{-16'sd4, 16'sd12, 16'sd3, 16'sd12};
        run_vector(v, "post_rst");

        // Back-to-back stream with both handshakes held high.
        for (int b = 0; b < 3; b++) bvec[b] = rand_vec();
        cyc = 0; acc_n = 0; res_n = 0; last_acc = 0;
        din = bvec[0];
        in_valid = 1'b1;
        out_ready = 1'b1;
        while (res_n < 3 && cyc < 100) begin
            if (out_valid) begin
                model(bvec[res_n]);
                check_out($sformatf("b2b%0d", res_n));
                res_n++;
            end
            accepting = in_ready && in_valid;
            @(posedge clk); #1;
            cyc++;
            if (accepting) begin
                if (acc_n > 0) check($sformatf("b2b%0d_gap", acc_n), cyc - last_acc, N + 2);
                last_acc = cyc;
                acc_n++;
                if (acc_n < 3) din = bvec[acc_n];
                else begin
                    in_valid = 1'b0;
                    scramble_in();
                end
            end
        end
        check("b2b_results", res_n, 3);
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(posedge clk); #1;

        // Random vectors
        for (int r = 0; r < 20; r++) begin
            v = rand_vec();
            run_vector(v, $sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/relu_argmax_stage.md
RELU_ARGMAX_STAGE -- requirements
Module: relu_argmax_stage

Interface
REQ-001 SHALL have parameter WIDTH, default 16, bit-width of each signed element.
REQ-002 SHALL have parameter N, default 4, vector length (number of neuron outputs consumed); N >= 2.
REQ-003 SHALL define IW = max(1, $clog2(N)) and CW = $clog2(N+1) as local widths.
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream vector valid.
REQ-007 SHALL have port in_ready, output, 1, stage can accept a vector.
REQ-008 SHALL have port in, input, signed [WIDTH-1:0] [0:N-1], pre-activation vector from the linear layer.
REQ-009 SHALL have port out_valid, output, 1, result valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts result.
REQ-011 SHALL have port act_out, output, signed [WIDTH-1:0] [0:N-1], ReLU of the captured vector.
REQ-012 SHALL have port max_idx, output, [IW-1:0], index of the largest activation.
REQ-013 SHALL have port max_val, output, signed [WIDTH-1:0], value of the largest activation.
REQ-014 SHALL have port num_active, output, [CW-1:0], count of strictly positive elements.

Function
REQ-015 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-016 SHALL drive in_ready = 1 only in IDLE; out_valid = 1 only in DONE.
REQ-017 IDLE: on in_valid && in_ready SHALL capture all N elements into an internal buffer, clear running max/idx/count to 0, set scan index to 0, go to SCAN.
REQ-018 SCAN: each cycle SHALL process buffer element at scan index k: act_out[k] <= (elem < 0) ? 0 : elem.
REQ-019 SCAN: if the activation of element k > running max (strict), running max <= that activation and max_idx <= k.
REQ-020 SCAN: if elem > 0, num_active increments by 1.
REQ-021 SCAN: after processing k = N-1, SHALL go to DONE; scan index SHALL NOT wrap to 0 while in SCAN.
REQ-022 Latency: out_valid SHALL rise exactly N cycles after the accepting edge.
REQ-023 DONE: outputs SHALL hold stable until out_valid && out_ready, then go to IDLE on that edge.
REQ-024 No bypass: a new vector SHALL NOT be accepted in the same cycle a result is consumed; the minimum period between accepts is N+2 cycles.
REQ-025 Ties SHALL resolve to the lowest index.
REQ-026 An all-nonpositive vector SHALL give max_val = 0, max_idx = 0, num_active = 0, and all act_out = 0.
REQ-027 Changes on in while not in IDLE SHALL NOT affect results.
REQ-028 Arithmetic: comparisons SHALL be signed WIDTH-bit; no saturation is needed, because ReLU cannot overflow.
REQ-029 act_out, max_idx, max_val, and num_active SHALL be registered, with no combinational path from in to any output.

Reset
REQ-030 On rst_n = 0 the block SHALL asynchronously enter IDLE and clear act_out, max_idx, max_val, num_active, scan index, and the buffer to 0.
REQ-031 On reset it SHALL set in_ready = 1 and out_valid = 0.
REQ-032 Reset asserted mid-SCAN or in DONE SHALL discard the in-flight vector; no out_valid SHALL follow.
REQ-033 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Verification
REQ-034 N=4, in={3,-2,7,1}: accept -> after 4 cycles out_valid=1, act_out={3,0,7,1}, max_idx=2, max_val=7, num_active=3.
REQ-035 in={5,5,-1,5} -> max_idx=0, max_val=5, num_active=3 (tie resolves to lowest index).
REQ-036 in={-1,-32768,0,-5} -> all act_out=0, max_idx=0, max_val=0, num_active=0.
REQ-037 Hold out_ready=0 for 10 cycles in DONE while toggling in/in_valid -> outputs stable, in_ready=0; then out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-038 Assert rst_n=0 at scan cycle 2 -> outputs zero immediately; out_valid never asserts for that vector; a new vector accepted after release completes normally.
REQ-039 Back-to-back stream of 3 vectors with in_valid always 1 and out_ready always 1 -> accepts spaced N+2 cycles apart, each result correct.
